// File: rtl/fpu_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// fpu_wb_ctrl_if : pipeline/divider/decode bundle for the FP writeback ctrl
// Revision       : 1.0
// ============================================================================
interface fpu_wb_ctrl_if #(
  parameter int NREG = 32
);
  localparam int WNW = $clog2(NREG);

  logic           stall;
  logic           fop_v;
  logic [WNW-1:0] fop_wn;
  logic [31:0]    fpu_res;
  logic           div_start;
  logic [WNW-1:0] div_wn;
  logic           div_done;
  logic [31:0]    div_res;
  logic [WNW-1:0] fs;
  logic [WNW-1:0] ft;
  logic           fs_rd;
  logic           ft_rd;
  logic           wey;
  logic [WNW-1:0] wny;
  logic [31:0]    dy;
  logic [1:0]     fwda;
  logic [1:0]     fwdb;
  logic           stall_req;
  logic           div_busy;

  modport master (
    output stall, fop_v, fop_wn, fpu_res,
    output div_start, div_wn, div_done, div_res,
    output fs, ft, fs_rd, ft_rd,
    input  wey, wny, dy, fwda, fwdb, stall_req, div_busy
  );

  modport slave (
    input  stall, fop_v, fop_wn, fpu_res,
    input  div_start, div_wn, div_done, div_res,
    input  fs, ft, fs_rd, ft_rd,
    output wey, wny, dy, fwda, fwdb, stall_req, div_busy
  );
endinterface
`default_nettype wire

// File: rtl/fpu_wb_ctrl.sv
`default_nettype none
// ============================================================================
// fpu_wb_ctrl : FP writeback/hazard controller; merges e3 and divider results
//               into register-file port y, drives decode stall and forwarding
// Revision    : 1.0
// ============================================================================
module fpu_wb_ctrl #(
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          clrn,
  fpu_wb_ctrl_if.slave  bus
);
  localparam int WNW = $clog2(NREG);

  localparam logic [1:0] c_fwd_rf = 2'b00;
  localparam logic [1:0] c_fwd_e3 = 2'b01;
  localparam logic [1:0] c_fwd_wb = 2'b10;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_E3   = 2'b01,
    WB_HOLD = 2'b10,
    WB_DIV  = 2'b11
  } wb_src_e;

  logic           e1v_q, e1v_d;
  logic [WNW-1:0] e1wn_q, e1wn_d;
  logic           e2v_q, e2v_d;
  logic [WNW-1:0] e2wn_q, e2wn_d;
  logic           e3v_q, e3v_d;
  logic [WNW-1:0] e3wn_q, e3wn_d;
  logic           hv_q, hv_d;
  logic [31:0]    hd_q, hd_d;
  logic           busy_q, busy_d;
  logic [WNW-1:0] dwn_q, dwn_d;
  logic           wey_q, wey_d;
  logic [WNW-1:0] wny_q, wny_d;
  logic [31:0]    dy_q, dy_d;

  logic           w_take_e3;
  logic           w_div_ok;
  wb_src_e        w_wb_src;

  // A divider result is accepted only while tracked and with no entry pending.
  always_comb begin
    w_take_e3 = e3v_q & ~bus.stall;
    w_div_ok  = bus.div_done & busy_q & ~hv_q;
    if (w_take_e3) begin
      w_wb_src = WB_E3;
    end else if (hv_q) begin
      w_wb_src = WB_HOLD;
    end else if (w_div_ok) begin
      w_wb_src = WB_DIV;
    end else begin
      w_wb_src = WB_NONE;
    end
  end

  always_comb begin
    e1v_d  = e1v_q;
    e1wn_d = e1wn_q;
    e2v_d  = e2v_q;
    e2wn_d = e2wn_q;
    e3v_d  = e3v_q;
    e3wn_d = e3wn_q;
    if (!bus.stall) begin
      e1v_d  = bus.fop_v;
      e1wn_d = bus.fop_wn;
      e2v_d  = e1v_q;
      e2wn_d = e1wn_q;
      e3v_d  = e2v_q;
      e3wn_d = e2wn_q;
    end
  end

  always_comb begin
    hv_d   = hv_q;
    hd_d   = hd_q;
    busy_d = busy_q;
    dwn_d  = dwn_q;
    if (w_take_e3 && w_div_ok) begin
      hv_d = 1'b1;
      hd_d = bus.div_res;
    end else if (w_wb_src == WB_HOLD) begin
      hv_d = 1'b0;
    end
    if (busy_q) begin
      if ((w_wb_src == WB_HOLD) || (w_wb_src == WB_DIV)) begin
        busy_d = 1'b0;
      end
    end else if (bus.div_start) begin
      busy_d = 1'b1;
      dwn_d  = bus.div_wn;
    end
  end

  // A bubble drops the enable but leaves number/data as last written.
  always_comb begin
    wey_d = 1'b0;
    wny_d = wny_q;
    dy_d  = dy_q;
    case (w_wb_src)
      WB_E3: begin
        wey_d = 1'b1;
        wny_d = e3wn_q;
        dy_d  = bus.fpu_res;
      end
      WB_HOLD: begin
        wey_d = 1'b1;
        wny_d = dwn_q;
        dy_d  = hd_q;
      end
      WB_DIV: begin
        wey_d = 1'b1;
        wny_d = dwn_q;
        dy_d  = bus.div_res;
      end
      default: begin
        wey_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1v_q  <= 1'b0;
      e1wn_q <= '0;
      e2v_q  <= 1'b0;
      e2wn_q <= '0;
      e3v_q  <= 1'b0;
      e3wn_q <= '0;
      hv_q   <= 1'b0;
      hd_q   <= '0;
      busy_q <= 1'b0;
      dwn_q  <= '0;
      wey_q  <= 1'b0;
      wny_q  <= '0;
      dy_q   <= '0;
    end else begin
      e1v_q  <= e1v_d;
      e1wn_q <= e1wn_d;
      e2v_q  <= e2v_d;
      e2wn_q <= e2wn_d;
      e3v_q  <= e3v_d;
      e3wn_q <= e3wn_d;
      hv_q   <= hv_d;
      hd_q   <= hd_d;
      busy_q <= busy_d;
      dwn_q  <= dwn_d;
      wey_q  <= wey_d;
      wny_q  <= wny_d;
      dy_q   <= dy_d;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic           rd,
    input logic [WNW-1:0] src,
    input logic           e3v,
    input logic [WNW-1:0] e3wn,
    input logic           wbv,
    input logic [WNW-1:0] wbwn
  );
    logic [1:0] sel;
    sel = c_fwd_rf;
    if (rd) begin
      if (e3v && (e3wn == src)) begin
        sel = c_fwd_e3;
      end else if (wbv && (wbwn == src)) begin
        sel = c_fwd_wb;
      end
    end
    return sel;
  endfunction

  // e1/e2 results and an outstanding divide are not forwardable yet.
  function automatic logic raw_hit(
    input logic           rd,
    input logic [WNW-1:0] src,
    input logic           v1,
    input logic [WNW-1:0] wn1,
    input logic           v2,
    input logic [WNW-1:0] wn2,
    input logic           dbusy,
    input logic [WNW-1:0] dwn
  );
    return rd && ((v1 && (wn1 == src)) ||
                  (v2 && (wn2 == src)) ||
                  (dbusy && (dwn == src)));
  endfunction

  logic w_raw_a;
  logic w_raw_b;
  logic w_waw;

  always_comb begin
    w_raw_a = raw_hit(bus.fs_rd, bus.fs, e1v_q, e1wn_q, e2v_q, e2wn_q, busy_q, dwn_q);
    w_raw_b = raw_hit(bus.ft_rd, bus.ft, e1v_q, e1wn_q, e2v_q, e2wn_q, busy_q, dwn_q);
    w_waw   = bus.fop_v & busy_q & (bus.fop_wn == dwn_q);
  end

  assign bus.fwda      = fwd_sel(bus.fs_rd, bus.fs, e3v_q, e3wn_q, wey_q, wny_q);
  assign bus.fwdb      = fwd_sel(bus.ft_rd, bus.ft, e3v_q, e3wn_q, wey_q, wny_q);
  assign bus.stall_req = w_raw_a | w_raw_b | w_waw;
  assign bus.div_busy  = busy_q;
  assign bus.wey       = wey_q;
  assign bus.wny       = wny_q;
  assign bus.dy        = dy_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fpu_wb_ctrl : directed scenarios plus randomized run against a model
// Revision       : 1.0
// ============================================================================
module tb_fpu_wb_ctrl;
  localparam int NREG = 32;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fpu_wb_ctrl_if #(.NREG(NREG)) bus ();
  fpu_wb_ctrl #(.NREG(NREG)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  always #5 clk = ~clk;

  // reference model state
  bit          m_v  [1:3];
  logic [4:0]  m_wn [1:3];
  bit          m_busy;
  logic [4:0]  m_dwn;
  logic [31:0] m_pend [$];
  bit          m_wey;
  logic [4:0]  m_wny;
  logic [31:0] m_dy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.fop_v = 0; bus.fop_wn = '0; bus.fpu_res = '0;
    bus.div_start = 0; bus.div_wn = '0; bus.div_done = 0; bus.div_res = '0;
    bus.fs = '0; bus.ft = '0; bus.fs_rd = 0; bus.ft_rd = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clrn = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 1'b0;
    bus.fop_v = 1; bus.fop_wn = 5'd5; bus.fs = 5'd5; bus.fs_rd = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL reset_wey: got %b want 0", bus.wey); end
      n_cmp++; if (bus.wny !== 5'd0) begin n_fail++; $display("FAIL reset_wny: got %0d want 0", bus.wny); end
      n_cmp++; if (bus.dy !== 32'd0) begin n_fail++; $display("FAIL reset_dy: got %h want 0", bus.dy); end
      n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req: got %b want 0", bus.stall_req); end
      n_cmp++; if (bus.fwda !== 2'b00) begin n_fail++; $display("FAIL reset_fwda: got %b want 00", bus.fwda); end
    end
    clrn = 1'b1;
    tick();
    bus.fop_v = 0;
    #1;
    n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL reset_first_edge_wey: got %b want 0", bus.wey); end
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_e1: got %b want 1", bus.stall_req); end
    n_cmp++; if (bus.div_busy !== 1'b0) begin n_fail++; $display("FAIL reset_div_busy: got %b want 0", bus.div_busy); end
  endtask

  task automatic test_pipelined_op();
    do_reset();
    bus.fop_v = 1; bus.fop_wn = 5'd5;
    tick();
    bus.fop_v = 0;
    tick();
    tick();
    bus.fpu_res = 32'h3F800000;
    #1;
    n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL pipe_t3_wey: got %b want 0", bus.wey); end
    tick();
    bus.fpu_res = 32'hDEADBEEF;
    n_cmp++; if (bus.wey !== 1'b1) begin n_fail++; $display("FAIL pipe_t4_wey: got %b want 1", bus.wey); end
    n_cmp++; if (bus.wny !== 5'd5) begin n_fail++; $display("FAIL pipe_t4_wny: got %0d want 5", bus.wny); end
    n_cmp++; if (bus.dy !== 32'h3F800000) begin n_fail++; $display("FAIL pipe_t4_dy: got %h want 3f800000", bus.dy); end
    tick();
    n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL pipe_bubble_wey: got %b want 0", bus.wey); end
    n_cmp++; if (bus.dy !== 32'h3F800000) begin n_fail++; $display("FAIL pipe_bubble_dy_hold: got %h want 3f800000", bus.dy); end
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.fop_v = 1; bus.fop_wn = 5'd7;
    bus.fs = 5'd7; bus.fs_rd = 1; bus.ft = 5'd7; bus.ft_rd = 0;
    tick();
    bus.fop_v = 0;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL fwd_t1_stall: got %b want 1", bus.stall_req); end
    tick();
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL fwd_t2_stall: got %b want 1", bus.stall_req); end
    tick();
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL fwd_t3_stall: got %b want 0", bus.stall_req); end
    n_cmp++; if (bus.fwda !== 2'b01) begin n_fail++; $display("FAIL fwd_t3_fwda: got %b want 01", bus.fwda); end
    n_cmp++; if (bus.fwdb !== 2'b00) begin n_fail++; $display("FAIL fwd_t3_fwdb_noread: got %b want 00", bus.fwdb); end
    tick();
    n_cmp++; if (bus.fwda !== 2'b10) begin n_fail++; $display("FAIL fwd_t4_fwda: got %b want 10", bus.fwda); end
    tick();
    n_cmp++; if (bus.fwda !== 2'b00) begin n_fail++; $display("FAIL fwd_t5_fwda: got %b want 00", bus.fwda); end
  endtask

  task automatic test_collision();
    do_reset();
    bus.div_start = 1; bus.div_wn = 5'd9; bus.fop_v = 1; bus.fop_wn = 5'd3;
    tick();
    bus.div_start = 0; bus.fop_v = 0;
    tick();
    tick();
    bus.div_done = 1; bus.div_res = 32'h40000000; bus.fpu_res = 32'h3F000000;
    tick();
    bus.div_done = 0; bus.fpu_res = 32'h0;
    n_cmp++; if (bus.wey !== 1'b1 || bus.wny !== 5'd3) begin n_fail++; $display("FAIL coll_t1: got wey=%b wny=%0d want 1/3", bus.wey, bus.wny); end
    n_cmp++; if (bus.dy !== 32'h3F000000) begin n_fail++; $display("FAIL coll_t1_dy: got %h want 3f000000", bus.dy); end
    n_cmp++; if (bus.div_busy !== 1'b1) begin n_fail++; $display("FAIL coll_t1_busy: got %b want 1", bus.div_busy); end
    tick();
    n_cmp++; if (bus.wey !== 1'b1 || bus.wny !== 5'd9) begin n_fail++; $display("FAIL coll_t2: got wey=%b wny=%0d want 1/9", bus.wey, bus.wny); end
    n_cmp++; if (bus.dy !== 32'h40000000) begin n_fail++; $display("FAIL coll_t2_dy: got %h want 40000000", bus.dy); end
    n_cmp++; if (bus.div_busy !== 1'b0) begin n_fail++; $display("FAIL coll_t2_busy: got %b want 0", bus.div_busy); end
    tick();
    n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL coll_t3_wey: got %b want 0", bus.wey); end
  endtask

  task automatic test_waw();
    do_reset();
    bus.div_start = 1; bus.div_wn = 5'd4;
    tick();
    bus.div_start = 0; bus.stall = 1; bus.fop_v = 1; bus.fop_wn = 5'd4;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL waw_stall0: got %b want 1", bus.stall_req); end
    bus.fop_wn = 5'd6;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL waw_other_reg: got %b want 0", bus.stall_req); end
    bus.fop_wn = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL waw_hold_%0d: got %b want 1", i, bus.stall_req); end
    end
    bus.div_done = 1; bus.div_res = 32'h12345678;
    tick();
    bus.div_done = 0;
    #1;
    n_cmp++; if (bus.wey !== 1'b1 || bus.wny !== 5'd4 || bus.dy !== 32'h12345678) begin
      n_fail++; $display("FAIL waw_wb: got %b/%0d/%h want 1/4/12345678", bus.wey, bus.wny, bus.dy);
    end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL waw_release: got %b want 0", bus.stall_req); end
    bus.stall = 0; bus.fop_v = 0;
  endtask

  task automatic test_stall_mid_pipe();
    int writes;
    do_reset();
    writes = 0;
    bus.fop_v = 1; bus.fop_wn = 5'd6;
    tick();
    bus.fop_v = 0;
    tick();
    tick();
    bus.stall = 1; bus.fpu_res = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL stall_wey_%0d: got %b want 0", i, bus.wey); end
    end
    bus.stall = 0; bus.fpu_res = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wey === 1'b1) begin
        writes++;
        n_cmp++; if (bus.wny !== 5'd6 || bus.dy !== 32'h22222222) begin
          n_fail++; $display("FAIL stall_wb_data: got %0d/%h want 6/22222222", bus.wny, bus.dy);
        end
      end
    end
    n_cmp++; if (writes != 1) begin n_fail++; $display("FAIL stall_write_count: got %0d want 1", writes); end
  endtask

  task automatic test_div_rules();
    do_reset();
    bus.div_done = 1; bus.div_res = 32'hAAAA0000;
    tick();
    bus.div_done = 0;
    n_cmp++; if (bus.wey !== 1'b0 || bus.div_busy !== 1'b0) begin n_fail++; $display("FAIL div_idle_done: got %b/%b want 0/0", bus.wey, bus.div_busy); end
    bus.div_start = 1; bus.div_wn = 5'd10;
    tick();
    bus.div_wn = 5'd11;
    tick();
    bus.div_wn = 5'd12; bus.div_done = 1; bus.div_res = 32'hCAFEF00D;
    tick();
    bus.div_start = 0; bus.div_done = 0;
    n_cmp++; if (bus.wey !== 1'b1 || bus.wny !== 5'd10 || bus.dy !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL div_first_wins: got %b/%0d/%h want 1/10/cafef00d", bus.wey, bus.wny, bus.dy);
    end
    n_cmp++; if (bus.div_busy !== 1'b0) begin n_fail++; $display("FAIL div_same_cycle_start: got %b want 0", bus.div_busy); end
    bus.div_start = 1; bus.div_wn = 5'd13;
    tick();
    bus.div_start = 0;
    clrn = 1'b0;
    #1;
    n_cmp++; if (bus.div_busy !== 1'b0 || bus.wey !== 1'b0) begin n_fail++; $display("FAIL div_async_reset: got %b/%b want 0/0", bus.div_busy, bus.wey); end
    tick();
    clrn = 1'b1;
    bus.div_done = 1; bus.div_res = 32'hBBBBBBBB;
    tick();
    bus.div_done = 0;
    n_cmp++; if (bus.wey !== 1'b0) begin n_fail++; $display("FAIL div_dropped_after_reset: got %b want 0", bus.wey); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.fop_v = 1; bus.fop_wn = 5'(k + 1);
      tick();
    end
    bus.fop_v = 0;
    for (int k = 0; k < 3; k++) begin
      bus.fpu_res = 32'hA0 + 32'(k);
      tick();
      n_cmp++; if (bus.wey !== 1'b1 || bus.wny !== 5'(k + 1) || bus.dy !== 32'hA0 + 32'(k)) begin
        n_fail++; $display("FAIL b2b_%0d: got %b/%0d/%h want 1/%0d/%h", k, bus.wey, bus.wny, bus.dy, k + 1, 32'hA0 + 32'(k));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    bit es, take, acc, was_busy;
    do_reset();
    for (int s = 1; s <= 3; s++) begin m_v[s] = 0; m_wn[s] = '0; end
    m_busy = 0; m_dwn = '0; m_pend.delete();
    m_wey = 0; m_wny = '0; m_dy = '0;
    for (int c = 0; c < 800; c++) begin
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.fop_v     = ($urandom_range(0, 1) == 1);
      bus.fop_wn    = 5'($urandom_range(0, 7));
      bus.fpu_res   = $urandom;
      bus.div_start = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 5) == 0);
      bus.div_wn    = 5'($urandom_range(0, 7));
      bus.div_done  = (m_busy && m_pend.size() == 0) ? ($urandom_range(0, 4) == 0)
                                                      : (!m_busy && $urandom_range(0, 19) == 0);
      bus.div_res   = $urandom;
      bus.fs        = 5'($urandom_range(0, 7));
      bus.ft        = 5'($urandom_range(0, 7));
      bus.fs_rd     = ($urandom_range(0, 3) != 0);
      bus.ft_rd     = ($urandom_range(0, 3) != 0);
      #2;
      ea = 2'b00;
      if (bus.fs_rd) begin
        if (m_v[3] && m_wn[3] == bus.fs) ea = 2'b01;
        else if (m_wey && m_wny == bus.fs) ea = 2'b10;
      end
      eb = 2'b00;
      if (bus.ft_rd) begin
        if (m_v[3] && m_wn[3] == bus.ft) eb = 2'b01;
        else if (m_wey && m_wny == bus.ft) eb = 2'b10;
      end
      es = 0;
      if (bus.fs_rd && ((m_v[1] && m_wn[1] == bus.fs) || (m_v[2] && m_wn[2] == bus.fs) || (m_busy && m_dwn == bus.fs))) es = 1;
      if (bus.ft_rd && ((m_v[1] && m_wn[1] == bus.ft) || (m_v[2] && m_wn[2] == bus.ft) || (m_busy && m_dwn == bus.ft))) es = 1;
      if (bus.fop_v && m_busy && bus.fop_wn == m_dwn) es = 1;
      n_cmp++; if (bus.fwda !== ea) begin n_fail++; $display("FAIL rnd_fwda c=%0d: got %b want %b", c, bus.fwda, ea); end
      n_cmp++; if (bus.fwdb !== eb) begin n_fail++; $display("FAIL rnd_fwdb c=%0d: got %b want %b", c, bus.fwdb, eb); end
      n_cmp++; if (bus.stall_req !== es) begin n_fail++; $display("FAIL rnd_stall_req c=%0d: got %b want %b", c, bus.stall_req, es); end
      n_cmp++; if (bus.div_busy !== m_busy) begin n_fail++; $display("FAIL rnd_div_busy c=%0d: got %b want %b", c, bus.div_busy, m_busy); end

      take     = m_v[3] && !bus.stall;
      acc      = bus.div_done && m_busy && (m_pend.size() == 0);
      was_busy = m_busy;
      if (take) begin
        m_wey = 1; m_wny = m_wn[3]; m_dy = bus.fpu_res;
        if (acc) m_pend.push_back(bus.div_res);
      end else if (m_pend.size() != 0) begin
        m_wey = 1; m_wny = m_dwn; m_dy = m_pend.pop_front(); m_busy = 0;
      end else if (acc) begin
        m_wey = 1; m_wny = m_dwn; m_dy = bus.div_res; m_busy = 0;
      end else begin
        m_wey = 0;
      end
      if (bus.div_start && !was_busy) begin m_busy = 1; m_dwn = bus.div_wn; end
      if (!bus.stall) begin
        m_v[3] = m_v[2]; m_wn[3] = m_wn[2];
        m_v[2] = m_v[1]; m_wn[2] = m_wn[1];
        m_v[1] = bus.fop_v; m_wn[1] = bus.fop_wn;
      end
      tick();
      n_cmp++; if (bus.wey !== m_wey || bus.wny !== m_wny || bus.dy !== m_dy) begin
        n_fail++; $display("FAIL rnd_wb c=%0d: got %b/%0d/%h want %b/%0d/%h", c, bus.wey, bus.wny, bus.dy, m_wey, m_wny, m_dy);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pipelined_op();
    test_forwarding();
    test_collision();
    test_waw();
    test_stall_mid_pipe();
    test_div_rules();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fpu_wb_ctrl.md
# fpu_wb_ctrl

FP writeback and hazard controller for the FPU pipeline. It tracks destination registers of pipelined FP ops through stages e1/e2/e3 and of the iterative divider, and merges both result streams into one registered write port. It sits directly upstream of the two-write-port FP register file, driving its port y (`wey`/`wny`/`dy`), and gives decode the stall and forwarding-select signals.

## Interface
- `NREG`, 32: number of FP registers; register number width is 5.
- `clk` in 1: clock, rising edge.
- `clrn` in 1: asynchronous reset, active low.
- `stall` in 1: front pipeline stall; holds e1, e2, e3.
- `fop_v` in 1: a pipelined FP op (add/sub/mul) enters e1 this cycle.
- `fop_wn` in 5: destination register of that op.
- `fpu_res` in 32: FPU datapath result for the op currently in e3.
- `div_start` in 1: divider issue.
- `div_wn` in 5: divider destination register.
- `div_done` in 1: one-cycle pulse, divider result valid.
- `div_res` in 32: divider result, valid with `div_done`.
- `fs`, `ft` in 5 each: decode source register numbers.
- `fs_rd`, `ft_rd` in 1 each: decode actually reads `fs` / `ft`.
- `wey` out 1: register-file port-y write enable (registered).
- `wny` out 5: port-y register number (registered).
- `dy` out 32: port-y data (registered).
- `fwda`, `fwdb` out 2 each: operand source for `fs` / `ft`; 00 = register file, 01 = `fpu_res` (e3), 10 = `dy` (wb).
- `stall_req` out 1: decode must stall (combinational).
- `div_busy` out 1: a divider result is not yet in wb.

## Operation
- **Pipeline tracking.** Valid/destination pairs e1v/e1wn, e2v/e2wn, e3v/e3wn.
  - When `stall`=0: e1 ← (`fop_v`, `fop_wn`), e2 ← e1, e3 ← e2.
  - When `stall`=1: e1, e2 and e3 all hold.
- **Divider tracking.**
  - `div_start` while `div_busy`=0: `div_busy` goes to 1 and `dwn` ← `div_wn`.
  - `div_start` while `div_busy`=1: ignored.
  - `div_done` while `div_busy`=0: ignored.
- **Divider hold buffer.** One entry (hv, hd). It captures `div_res` on `div_done` only when the wb slot is taken by e3.
- **wb stage selection.** The wb register holds `wey`/`wny`/`dy`. At each edge it loads the first of these that applies:
  1. e3 result (e3v, e3wn, `fpu_res`) if e3v=1 and `stall`=0.
  2. The hold buffer if hv=1; hv clears.
  3. The divider result directly if `div_done`=1.
  4. Otherwise a bubble: `wey`=0, while `wny`/`dy` keep their previous values.
- **`div_busy` clear.** `div_busy` clears on the edge where the divider result enters wb, by rule 2 or rule 3.
- **Forwarding, per source, checked in priority order:**
  - match with e3v && e3wn → 01;
  - else match with `wey` && `wny` → 10;
  - else 00.
  - `fwda`/`fwdb` are 00 whenever `fs_rd`/`ft_rd` is 0.
- **`stall_req` is 1 when any of these hold:**
  - RAW on e1/e2: a read source matches e1wn (with e1v) or e2wn (with e2v). Those results are not yet available.
  - RAW on the divider: `div_busy` and a read source equals `dwn`.
  - WAW: `fop_v` with `fop_wn` == `dwn` while `div_busy`. This guarantees no pipelined write can overtake or collide with a pending divide to the same register.
- **Port-y priority.** The pipelined result always wins port y. The divider waits at most one slot in hold; because hv is drained by rule 2, at most one divider result is ever pending.

## Timing
- **Reset (`clrn`=0, asynchronous).** All of the following go to 0:
  - state: e1v, e2v, e3v, hv, `div_busy`, `dwn`;
  - port-y outputs: `wey`, `wny`, `dy`.
  - With that state, `fwda`, `fwdb` and `stall_req` evaluate to 0.
  - Reset mid-divide drops the result; a later `div_done` is ignored because `div_busy` is 0.
- **Pipelined op latency.** Issued in cycle t with no stalls: e1 at t+1, e2 at t+2, e3 at t+3, `wey`=1 at t+4.
- **Divider latency.** `div_done` at cycle t:
  - `wey`=1 at t+1 if no e3 write competes at t;
  - otherwise the result goes into hold at t+1 and `wey`=1 at t+2.
- **Stall with e3 valid.** wb does not take e3, so no duplicate write. The slot may drain hold or `div_done`.
- **`div_done` and `div_start` in the same cycle.** The old result completes. The new start is ignored because `div_busy` is still 1 in that cycle.

## Test plan
- **Reset.** Hold `clrn`=0 with `fop_v`=1 → `wey`=0, `wny`=0, `dy`=0, `stall_req`=0 throughout; first edge after release loads only e1.
- **Pipelined op.** `fop_v`, `fop_wn`=5 at t, `fpu_res`=32'h3F800000 at t+3 → `wey`=1, `wny`=5, `dy`=32'h3F800000 at t+4.
- **Forwarding and RAW.** Op to f7 issued at t; decode `fs`=7, `fs_rd`=1:
  - t+1, t+2 → `stall_req`=1;
  - t+3 → `fwda`=01;
  - t+4 → `fwda`=10;
  - t+5 → `fwda`=00.
- **Collision.** e3 holds f3 and `div_done` for f9 (`div_res`=32'h40000000) in the same cycle t → t+1: `wny`=3; t+2: `wny`=9, `dy`=32'h40000000; `div_busy` low after the t+2 edge.
- **WAW.** `div_busy` with `dwn`=4, then `fop_v` with `fop_wn`=4 → `stall_req`=1 until the divider result reaches wb.
- **Stall mid-pipe.** `stall`=1 for 2 cycles while e3 is valid → `wey`=0 during the stall; exactly one write for the op once `stall` falls.
